// File: rtl/relu_channel_serializer.sv
// relu_channel_serializer
// Takes one packed vector of CHANNELS activations from the relu layer and
// replays it one channel per beat, channel 0 first, on a narrow valid/ready
// stream. It also gives the channel index and a last-channel flag.
//
// The held vector only changes when a new vector is accepted. That happens in
// IDLE, or in the same cycle that the final beat of the current vector leaves.
// Because of this, back-to-back vectors stream with no idle beat between them.
// Every output is a mux from registers. The only combinational path through
// the block is out_ready -> in_ready.
module relu_channel_serializer #(
    parameter int I_WIDTH  = 16,
    parameter int CHANNELS = 4,
    localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [I_WIDTH*CHANNELS-1:0]   input_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [I_WIDTH-1:0]            output_data,
    output logic [CH_BITS-1:0]            out_channel,
    output logic                          out_last
);

    localparam logic [CH_BITS-1:0] LAST_IDX = CH_BITS'(CHANNELS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                        r_state;
    state_t                        w_nextState;
    logic [I_WIDTH*CHANNELS-1:0]   r_holdReg;
    logic [CH_BITS-1:0]            r_idx;
    logic                          w_isLast;
    logic                          w_beat;
    logic                          w_inXfer;
    logic [I_WIDTH-1:0]            w_selData;

    assign w_isLast = (r_idx == LAST_IDX);
    assign w_beat   = (r_state == SEND) && out_ready;
    assign w_inXfer = in_valid && in_ready;

    // State register; reset drops any partially sent vector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: leave SEND only when the last beat goes and nothing is waiting
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                if (w_beat && w_isLast && !in_valid) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Handshake outputs; in_ready opens on the last beat so the next vector overlaps it
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = w_isLast;
                in_ready  = w_isLast && out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Held vector and channel pointer; a new capture always restarts at channel 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_holdReg <= '0;
            r_idx     <= '0;
        end else if (w_inXfer) begin
            r_holdReg <= input_data;
            r_idx     <= '0;
        end else if (w_beat) begin
            r_idx <= w_isLast ? '0 : r_idx + CH_BITS'(1);
        end
    end

    // Channel mux from the held vector, built with constant slices only
    always_comb begin
        w_selData = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_idx == CH_BITS'(c)) begin
                w_selData = r_holdReg[c*I_WIDTH +: I_WIDTH];
            end
        end
    end

    assign output_data = w_selData;
    assign out_channel = r_idx;

endmodule

// File: tb/tb_relu_channel_serializer.sv
// Self-checking bench for relu_channel_serializer.
// Two instances: A (I_WIDTH=8, CHANNELS=4) and B (I_WIDTH=16, CHANNELS=1).
// The reference for each instance is a queue of pending beats. An accepted
// vector expands into CHANNELS beats, and each transferred beat pops one off.
module tb_relu_channel_serializer;

    localparam int WA = 8;
    localparam int CA = 4;
    localparam int WB = 16;
    localparam int CB = 1;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstA, in_validA, in_readyA, out_validA, out_readyA, out_lastA;
    logic [WA*CA-1:0]  input_dataA;
    logic [WA-1:0]     output_dataA;
    logic [1:0]        out_channelA;

    logic              rstB, in_validB, in_readyB, out_validB, out_readyB, out_lastB;
    logic [WB*CB-1:0]  input_dataB;
    logic [WB-1:0]     output_dataB;
    logic [0:0]        out_channelB;

    relu_channel_serializer #(.I_WIDTH(WA), .CHANNELS(CA)) dutA (
        .clk(clk), .rst(rstA),
        .in_valid(in_validA), .in_ready(in_readyA), .input_data(input_dataA),
        .out_valid(out_validA), .out_ready(out_readyA), .output_data(output_dataA),
        .out_channel(out_channelA), .out_last(out_lastA)
    );

    relu_channel_serializer #(.I_WIDTH(WB), .CHANNELS(CB)) dutB (
        .clk(clk), .rst(rstB),
        .in_valid(in_validB), .in_ready(in_readyB), .input_data(input_dataB),
        .out_valid(out_validB), .out_ready(out_readyB), .output_data(output_dataB),
        .out_channel(out_channelB), .out_last(out_lastB)
    );

    typedef struct {
        logic [31:0] data;
        int          ch;
        bit          last;
    } beat_t;

    beat_t       expA[$];
    beat_t       expB[$];
    logic [31:0] logA[$];
    logic [31:0] logB[$];
    int          logCycA[$];
    int          logCycB[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          inCountA = 0;
    int          readyModeA = 0;
    int          readyModeB = 0;
    bit          inTookA = 1'b0;
    bit          inTookB = 1'b0;
    bit          postRstA = 1'b0;
    bit          postRstB = 1'b0;
    bit          eVA, eRA, eVB, eRB;
    beat_t       bA, bB;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for A: compare on the falling edge, then advance the queue for the coming rising edge
    always @(negedge clk) begin
        cyc++;
        eVA = (expA.size() > 0);
        eRA = (expA.size() == 0) || (expA.size() == 1 && out_readyA);
        checkOutput("A.in_ready", 32'(in_readyA), 32'(eRA));
        checkOutput("A.out_valid", 32'(out_validA), 32'(eVA));
        checkOutput("A.out_last", 32'(out_lastA), eVA ? 32'(expA[0].last) : 32'd0);
        if (eVA) begin
            checkOutput("A.output_data", 32'(output_dataA), expA[0].data);
            checkOutput("A.out_channel", 32'(out_channelA), 32'(expA[0].ch));
        end
        if (postRstA) begin
            checkOutput("A.reset_data", 32'(output_dataA), 32'd0);
            checkOutput("A.reset_channel", 32'(out_channelA), 32'd0);
        end
        inTookA = !rstA && in_validA && eRA;
        if (rstA) begin
            expA.delete();
            postRstA = 1'b1;
        end else begin
            postRstA = 1'b0;
            if (eVA && out_readyA) begin
                logA.push_back(32'(output_dataA));
                logCycA.push_back(cyc);
                void'(expA.pop_front());
            end
            if (inTookA) begin
                inCountA++;
                for (int c = 0; c < CA; c++) begin
                    bA.data = 32'((input_dataA >> (c*WA)) & 32'hFF);
                    bA.ch   = c;
                    bA.last = (c == CA-1);
                    expA.push_back(bA);
                end
            end
        end
    end

    // Reference model for B, the single-channel instance
    always @(negedge clk) begin
        eVB = (expB.size() > 0);
        eRB = (expB.size() == 0) || (expB.size() == 1 && out_readyB);
        checkOutput("B.in_ready", 32'(in_readyB), 32'(eRB));
        checkOutput("B.out_valid", 32'(out_validB), 32'(eVB));
        checkOutput("B.out_last", 32'(out_lastB), eVB ? 32'(expB[0].last) : 32'd0);
        if (eVB) begin
            checkOutput("B.output_data", 32'(output_dataB), expB[0].data);
            checkOutput("B.out_channel", 32'(out_channelB), 32'(expB[0].ch));
        end
        if (postRstB) begin
            checkOutput("B.reset_data", 32'(output_dataB), 32'd0);
        end
        inTookB = !rstB && in_validB && eRB;
        if (rstB) begin
            expB.delete();
            postRstB = 1'b1;
        end else begin
            postRstB = 1'b0;
            if (eVB && out_readyB) begin
                logB.push_back(32'(output_dataB));
                logCycB.push_back(cyc);
                void'(expB.pop_front());
            end
            if (inTookB) begin
                for (int c = 0; c < CB; c++) begin
                    bB.data = 32'((input_dataB >> (c*WB)) & 32'hFFFF);
                    bB.ch   = c;
                    bB.last = (c == CB-1);
                    expB.push_back(bB);
                end
            end
        end
    end

    // Downstream ready generator: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
    initial begin
        int k;
        k = 0;
        out_readyA = 1'b1;
        out_readyB = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyModeA)
                0:       out_readyA = 1'b1;
                1:       out_readyA = (k % 3 == 0);
                default: out_readyA = 1'($urandom_range(0, 1));
            endcase
            case (readyModeB)
                0:       out_readyB = 1'b1;
                default: out_readyB = 1'($urandom_range(0, 1));
            endcase
            k++;
        end
    end

    // Offer one vector and hold it until the model reports it taken
    task automatic applyStimulus(input bit useB, input logic [31:0] v);
        int n;
        bit took;
        n = 0;
        took = 1'b0;
        if (useB) begin
            in_validB = 1'b1;
            input_dataB = v[15:0];
        end else begin
            in_validA = 1'b1;
            input_dataA = v;
        end
        do begin
            @(posedge clk);
            #1;
            n++;
            took = useB ? inTookB : inTookA;
        end while (!took && n < 200);
        checkOutput(useB ? "B.accept" : "A.accept", 32'(took), 32'd1);
    endtask

    // Drop in_valid and wait for every pending beat to leave
    task automatic drain(input bit useB);
        int n;
        n = 0;
        if (useB) in_validB = 1'b0;
        else      in_validA = 1'b0;
        while ((useB ? expB.size() : expA.size()) != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(useB ? "B.drain" : "A.drain", 32'(useB ? expB.size() : expA.size()), 32'd0);
    endtask

    task automatic checkLog(input string name, input bit useB, input logic [31:0] exp [8], input int n);
        int sz;
        sz = useB ? logB.size() : logA.size();
        checkOutput({name, ".count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            checkOutput(name, useB ? logB[i] : logA[i], exp[i]);
        end
    endtask

    task automatic clearLogs();
        logA.delete();
        logCycA.delete();
        logB.delete();
        logCycB.delete();
    endtask

    // Global time limit so the run always ends
    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequences, then randomized traffic, then the summary
    initial begin
        logic [31:0] seq [8];
        int c0;
        int idle;
        rstA = 1'b1; rstB = 1'b1;
        in_validA = 1'b0; in_validB = 1'b0;
        input_dataA = '0; input_dataB = '0;
        repeat (3) @(posedge clk);
        #1;
        rstA = 1'b0; rstB = 1'b0;
        checkOutput("A.rst_in_ready", 32'(in_readyA), 32'd1);
        checkOutput("A.rst_out_valid", 32'(out_validA), 32'd0);
        checkOutput("A.rst_data", 32'(output_dataA), 32'd0);

        clearLogs();
        applyStimulus(1'b0, 32'h44332211);
        drain(1'b0);
        seq = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0, 32'h0, 32'h0};
        checkLog("A.single", 1'b0, seq, 4);
        checkOutput("A.single_idle_ready", 32'(in_readyA), 32'd1);

        clearLogs();
        applyStimulus(1'b0, 32'h44332211);
        applyStimulus(1'b0, 32'h88776655);
        drain(1'b0);
        seq = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
        checkLog("A.b2b", 1'b0, seq, 8);
        if (logCycA.size() == 8) checkOutput("A.b2b_span", 32'(logCycA[7] - logCycA[0]), 32'd7);

        readyModeA = 1;
        clearLogs();
        applyStimulus(1'b0, 32'h44332211);
        applyStimulus(1'b0, 32'h88776655);
        drain(1'b0);
        checkLog("A.backpressure", 1'b0, seq, 8);
        readyModeA = 0;

        clearLogs();
        c0 = inCountA;
        applyStimulus(1'b0, 32'h44332211);
        in_validA = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h88776655);
        drain(1'b0);
        checkLog("A.stall", 1'b0, seq, 8);
        checkOutput("A.stall_accepts", 32'(inCountA - c0), 32'd2);

        clearLogs();
        applyStimulus(1'b0, 32'h44332211);
        in_validA = 1'b0;
        for (int i = 0; i < 20 && logA.size() < 2; i++) begin
            @(posedge clk);
            #1;
        end
        rstA = 1'b1;
        in_validA = 1'b1;
        input_dataA = 32'hFFEEDDCC;
        @(posedge clk);
        #1;
        rstA = 1'b0;
        in_validA = 1'b0;
        checkOutput("A.midrst_out_valid", 32'(out_validA), 32'd0);
        checkOutput("A.midrst_data", 32'(output_dataA), 32'd0);
        checkOutput("A.midrst_in_ready", 32'(in_readyA), 32'd1);
        checkOutput("A.midrst_beats", 32'(logA.size()), 32'd2);
        clearLogs();
        applyStimulus(1'b0, 32'hDDCCBBAA);
        drain(1'b0);
        seq = '{32'hAA, 32'hBB, 32'hCC, 32'hDD, 32'h0, 32'h0, 32'h0, 32'h0};
        checkLog("A.after_rst", 1'b0, seq, 4);

        readyModeA = 2;
        for (int v = 0; v < 150; v++) begin
            idle = $urandom_range(0, 2);
            in_validA = 1'b0;
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(1'b0, $urandom());
        end
        drain(1'b0);
        readyModeA = 0;

        clearLogs();
        applyStimulus(1'b1, 32'h1234);
        applyStimulus(1'b1, 32'hABCD);
        drain(1'b1);
        seq = '{32'h1234, 32'hABCD, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        checkLog("B.b2b", 1'b1, seq, 2);
        if (logCycB.size() == 2) checkOutput("B.b2b_span", 32'(logCycB[1] - logCycB[0]), 32'd1);

        readyModeB = 1;
        for (int v = 0; v < 40; v++) begin
            idle = $urandom_range(0, 1);
            in_validB = 1'b0;
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(1'b1, $urandom());
        end
        drain(1'b1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
